// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants and types for the EX-stage branch resolution controller.
package branch_resolve_ctrl_pkg;

    localparam logic [2:0] BRANCH_BEQ  = 3'b000;
    localparam logic [2:0] BRANCH_BNE  = 3'b001;
    localparam logic [2:0] BRANCH_BLT  = 3'b100;
    localparam logic [2:0] BRANCH_BGE  = 3'b101;
    localparam logic [2:0] BRANCH_BLTU = 3'b110;
    localparam logic [2:0] BRANCH_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESOLVE  = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [1:0] BHT_RESET = 2'b01;

    // Saturating 2-bit counter step.
    function automatic logic [1:0] bht_next(input logic [1:0] ctr,
                                            input logic       taken);
        if (taken)
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table of 2-bit counters: async read port, sync write port.
module branch_bht
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] ctr [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= BHT_RESET;
        end else if (wr_en) begin
            ctr[wr_idx] <= bht_next(ctr[wr_idx], wr_taken);
        end
    end

    // No write bypass: a same-cycle read sees the old counter.
    assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/branch_conditional.sv
// Branch comparator: evaluates a funct3 compare op on two operands.
module branch_conditional
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (op)
            BRANCH_BEQ:  taken = (a == b);
            BRANCH_BNE:  taken = (a != b);
            BRANCH_BLT:  taken = ($signed(a) <  $signed(b));
            BRANCH_BGE:  taken = ($signed(a) >= $signed(b));
            BRANCH_BLTU: taken = (a <  b);
            BRANCH_BGEU: taken = (a >= b);
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX branch/jump resolution, mispredict redirect and BHT training.
// Optional BRANCH_STATS_EN adds branch / mispredict counters.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int BHT_IDX_W = 6,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_branch_op,
    input  logic            req_is_jal,
    input  logic            req_is_jalr,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [XLEN-1:0] req_imm,
    input  logic            req_pred_taken,
    input  logic [XLEN-1:0] req_pred_target,
    input  logic            flush,
    output logic            res_valid,
    output logic            res_taken,
    output logic [XLEN-1:0] res_link,
    output logic            res_misalign,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    state_t state, state_next;

    logic            up;
    logic [2:0]      op_q;
    logic            jal_q, jalr_q, pt_q;
    logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q, ptgt_q;

    logic            accept, cmp_taken, taken, cond;
    logic            misalign, mispredict, bht_we, go_redir;
    logic [XLEN-1:0] jalr_sum, target, link, next_pc;
    logic            unused_pred_bits;

    // Held low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) up <= 1'b0;
        else        up <= 1'b1;
    end

    assign req_ready = up && (state == ST_IDLE) && !flush;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            jal_q  <= 1'b0;
            jalr_q <= 1'b0;
            pt_q   <= 1'b0;
            pc_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            imm_q  <= '0;
            ptgt_q <= '0;
        end else if (accept) begin
            op_q   <= req_branch_op;
            jal_q  <= req_is_jal;
            jalr_q <= req_is_jalr;
            pt_q   <= req_pred_taken;
            pc_q   <= req_pc;
            rs1_q  <= req_rs1;
            rs2_q  <= req_rs2;
            imm_q  <= req_imm;
            ptgt_q <= req_pred_target;
        end
    end

    branch_conditional #(.XLEN(XLEN)) u_cmp (
        .op    (op_q),
        .a     (rs1_q),
        .b     (rs2_q),
        .taken (cmp_taken)
    );

    assign cond       = !jal_q && !jalr_q;
    assign taken      = !cond || cmp_taken;
    assign jalr_sum   = rs1_q + imm_q;
    assign target     = jalr_q ? (jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1})
                               : pc_q + imm_q;
    assign link       = pc_q + XLEN'(4);
    assign next_pc    = taken ? target : link;
    assign misalign   = taken && target[1];
    assign mispredict = (taken != pt_q) || (taken && (ptgt_q != target));

    always_comb begin
        state_next  = state;
        res_valid   = 1'b0;
        redir_valid = 1'b0;
        bht_we      = 1'b0;
        go_redir    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                state_next = ST_IDLE;
                if (!flush) begin
                    res_valid = 1'b1;
                    bht_we    = cond && !misalign;
                    go_redir  = mispredict && !misalign;
                    if (go_redir) state_next = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    redir_valid = 1'b1;
                    if (redir_ready) state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        redir_pc <= '0;
        else if (go_redir) redir_pc <= next_pc;
    end

    assign res_taken    = res_valid && taken;
    assign res_misalign = res_valid && misalign;
    assign res_link     = res_valid ? link : '0;

    branch_bht #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (pred_pc[BHT_IDX_W+1:2]),
        .rd_taken (pred_taken),
        .wr_en    (bht_we),
        .wr_idx   (pc_q[BHT_IDX_W+1:2]),
        .wr_taken (taken)
    );

    assign unused_pred_bits = ^{pred_pc[XLEN-1:BHT_IDX_W+2], pred_pc[1:0]};

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (res_valid) stat_branches    <= stat_branches + 32'd1;
            if (go_redir)  stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule
